// File: rtl/wvf_dac_spi_driver.sv
// wvf_dac_spi_driver
// Takes LUT samples over a valid/ready handshake, converts each one to an
// offset-binary DAC code and sends it as a 16-bit SPI frame {CMD_WORD, code}.
// An LDAC_N load strobe follows every frame. Frames whose sample carried the
// end-of-table flag increment a wrapping waveform-period counter.
module wvf_dac_spi_driver #(
  parameter int         BIT_WIDTH = 12,
  parameter int         SIGNED_IN = 1,
  parameter logic [3:0] CMD_WORD  = 4'b0011,
  parameter int         CLK_DIV   = 4,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 CLK_SYS,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [BIT_WIDTH-1:0] DATA_IN,
  input  logic                 DATA_VALID,
  input  logic                 DATA_END,
  output logic                 DATA_READY,
  output logic                 SPI_SCLK,
  output logic                 SPI_MOSI,
  output logic                 SPI_CS_N,
  output logic                 SPI_LDAC_N,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] PERIOD_CNT
);

  localparam int                   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_WIDTH-1:0] SIGN_BIT = BIT_WIDTH'(1 << (BIT_WIDTH - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CS_HOLD,
    S_LDAC
  } state_t;

  state_t               state, state_next;

  logic [BIT_WIDTH-1:0] hold_data;
  logic                 hold_end;
  logic                 hold_full;
  logic                 end_flag;
  logic [15:0]          shift_reg;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           bit_cnt;
  logic                 sclk_phase;

  logic                 div_done;
  logic                 last_bit;
  logic [BIT_WIDTH-1:0] conv;
  logic [11:0]          code12;
  logic [15:0]          frame;

  assign DATA_READY = EN & ~hold_full;

  // Flipping the sign bit of a two's-complement sample gives offset binary;
  // narrower samples are left-justified into the 12-bit DAC code.
  assign conv     = (SIGNED_IN != 0) ? (hold_data ^ SIGN_BIT) : hold_data;
  assign code12   = 12'(conv) << (12 - BIT_WIDTH);
  assign frame    = {CMD_WORD, code12};

  assign div_done = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == 4'd15);

  // FSM state register.
  always_ff @(posedge CLK_SYS) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and SPI pin decode from the current state.
  always_comb begin
    // NOTE: all outputs get a default before the case so no path infers a latch.
    state_next = state;
    SPI_SCLK   = 1'b0;
    SPI_MOSI   = 1'b0;
    SPI_CS_N   = 1'b1;
    SPI_LDAC_N = 1'b1;
    BUSY       = 1'b1;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (hold_full) state_next = S_LOAD;
      end
      S_LOAD: begin
        SPI_CS_N   = 1'b0;
        SPI_MOSI   = CMD_WORD[3];  // frame MSB is always the command MSB
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        SPI_CS_N = 1'b0;
        SPI_SCLK = sclk_phase;
        SPI_MOSI = shift_reg[15];
        if (div_done && sclk_phase && last_bit) state_next = S_CS_HOLD;
      end
      S_CS_HOLD: begin
        SPI_CS_N = 1'b0;
        if (div_done) state_next = S_LDAC;
      end
      S_LDAC: begin
        SPI_LDAC_N = 1'b0;
        if (div_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Dropping EN abandons any frame; LDAC is never reached for it.
    if (!EN) state_next = S_IDLE;
  end

  // Sample and frame storage; validity is tracked by hold_full and the FSM state.
  always_ff @(posedge CLK_SYS) begin
    // NOTE: pure data registers carry no reset; nothing reads them until qualified.
    if (DATA_VALID && DATA_READY) begin
      hold_data <= DATA_IN;
      hold_end  <= DATA_END;
    end
    if (state == S_LOAD) begin
      shift_reg <= frame;
      end_flag  <= hold_end;
    end else if (state == S_SHIFT && div_done && sclk_phase && !last_bit) begin
      shift_reg <= {shift_reg[14:0], 1'b0};
    end
  end

  // Handshake flags, SCLK timing counters, overrun flag and period counter.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      hold_full  <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk_phase <= 1'b0;
      OVERRUN    <= 1'b0;
      PERIOD_CNT <= '0;
    end else if (!EN) begin
      hold_full  <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk_phase <= 1'b0;
    end else begin
      // With EN high, DATA_READY is simply ~hold_full.
      if (DATA_VALID && hold_full) OVERRUN   <= 1'b1;
      else if (DATA_VALID)         hold_full <= 1'b1;

      case (state)
        S_LOAD: begin
          hold_full  <= 1'b0;  // no accept can coincide: DATA_READY is low here
          div_cnt    <= '0;
          bit_cnt    <= '0;
          sclk_phase <= 1'b0;
        end
        S_SHIFT: begin
          if (div_done) begin
            div_cnt    <= '0;
            sclk_phase <= ~sclk_phase;
            if (sclk_phase && !last_bit) bit_cnt <= bit_cnt + 4'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_CS_HOLD: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
        end
        S_LDAC: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
          if (div_done && end_flag) PERIOD_CNT <= PERIOD_CNT + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wvf_dac_spi_driver.sv
// Testbench for wvf_dac_spi_driver. Three instances share one stimulus bus:
//   dut_a : 12-bit signed input, 16-bit period counter (default build)
//   dut_b : 8-bit unsigned input
//   dut_c : default build with a 2-bit period counter (wrap)
// A pin-level SPI monitor decodes frames; expectations come from a table
// and from an arithmetic model of the DAC code.
module tb_wvf_dac_spi_driver;

  localparam logic [3:0] CMD = 4'b0011;

  logic        clk = 1'b0;
  logic        rst, en, valid, dend;
  logic [11:0] data;

  logic        a_ready, a_sclk, a_mosi, a_cs_n, a_ldac_n, a_busy, a_ovr;
  logic [15:0] a_cnt;
  logic        b_ready, b_sclk, b_mosi, b_cs_n, b_ldac_n, b_busy, b_ovr;
  logic [15:0] b_cnt;
  logic        c_ready, c_sclk, c_mosi, c_cs_n, c_ldac_n, c_busy, c_ovr;
  logic [1:0]  c_cnt;

  always #5 clk = ~clk;

  wvf_dac_spi_driver #(.BIT_WIDTH(12), .SIGNED_IN(1), .CNT_WIDTH(16)) dut_a (
    .CLK_SYS(clk), .RST(rst), .EN(en), .DATA_IN(data), .DATA_VALID(valid),
    .DATA_END(dend), .DATA_READY(a_ready), .SPI_SCLK(a_sclk), .SPI_MOSI(a_mosi),
    .SPI_CS_N(a_cs_n), .SPI_LDAC_N(a_ldac_n), .BUSY(a_busy), .OVERRUN(a_ovr),
    .PERIOD_CNT(a_cnt));

  wvf_dac_spi_driver #(.BIT_WIDTH(8), .SIGNED_IN(0), .CNT_WIDTH(16)) dut_b (
    .CLK_SYS(clk), .RST(rst), .EN(en), .DATA_IN(data[7:0]), .DATA_VALID(valid),
    .DATA_END(dend), .DATA_READY(b_ready), .SPI_SCLK(b_sclk), .SPI_MOSI(b_mosi),
    .SPI_CS_N(b_cs_n), .SPI_LDAC_N(b_ldac_n), .BUSY(b_busy), .OVERRUN(b_ovr),
    .PERIOD_CNT(b_cnt));

  wvf_dac_spi_driver #(.BIT_WIDTH(12), .SIGNED_IN(1), .CNT_WIDTH(2)) dut_c (
    .CLK_SYS(clk), .RST(rst), .EN(en), .DATA_IN(data), .DATA_VALID(valid),
    .DATA_END(dend), .DATA_READY(c_ready), .SPI_SCLK(c_sclk), .SPI_MOSI(c_mosi),
    .SPI_CS_N(c_cs_n), .SPI_LDAC_N(c_ldac_n), .BUSY(c_busy), .OVERRUN(c_ovr),
    .PERIOD_CNT(c_cnt));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // ---------------- SPI pin monitor (samples 2 time units after each rising edge)
  int          cyc = 0;
  logic        pa_cs = 1'b1, pa_sclk = 1'b0, pa_ldac = 1'b1, pb_cs = 1'b1, pb_sclk = 1'b0;
  logic [15:0] sh_a = '0, sh_b = '0;
  int          nb_a = 0, nb_b = 0;
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  int          cs_fall_cyc = 0, ldac_rise_cyc = 0, last_gap = 0, last_len = 0;
  int          ldac_w = 0, last_ldac_w = 0, ldac_pulses = 0, aborts = 0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (pa_cs && !a_cs_n) begin
      cs_fall_cyc = cyc;
      last_gap    = cyc - ldac_rise_cyc;
      nb_a        = 0;
    end
    if (!pa_sclk && a_sclk) begin
      sh_a = {sh_a[14:0], a_mosi};
      nb_a++;
    end
    if (!pa_cs && a_cs_n) begin
      if (nb_a == 16) got_a.push_back(sh_a);
      else            aborts++;
    end
    if (!a_ldac_n) ldac_w++;
    if (!pa_ldac && a_ldac_n) begin
      ldac_pulses++;
      last_ldac_w   = ldac_w;
      ldac_w        = 0;
      last_len      = cyc - cs_fall_cyc;
      ldac_rise_cyc = cyc;
    end
    if (pb_cs && !b_cs_n) nb_b = 0;
    if (!pb_sclk && b_sclk) begin
      sh_b = {sh_b[14:0], b_mosi};
      nb_b++;
    end
    if (!pb_cs && b_cs_n && nb_b == 16) got_b.push_back(sh_b);
    pa_cs = a_cs_n; pa_sclk = a_sclk; pa_ldac = a_ldac_n;
    pb_cs = b_cs_n; pb_sclk = b_sclk;
  end

  // ---------------- reference model: offset binary = sample + half scale (mod 2^12)
  function automatic logic [15:0] model_a(input logic [11:0] d);
    logic [11:0] code;
    code = 12'((int'(d) + 2048) % 4096);
    return {CMD, code};
  endfunction

  function automatic logic [15:0] model_b(input logic [7:0] d);
    logic [11:0] code;
    code = 12'(int'(d) * 16);
    return {CMD, code};
  endfunction

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          exp_periods = 0;

  // ---------------- stimulus helpers (inputs change on falling edges)
  task automatic send(input logic [11:0] d, input logic e);
    int k = 0;
    while (!a_ready && k < 2000) begin @(negedge clk); k++; end
    if (!a_ready) timeout("send_ready");
    data = d; dend = e; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; dend = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string nm);
    int k = 0;
    while ((got_a.size() < n || got_b.size() < n) && k < 1000) begin @(negedge clk); k++; end
    if (got_a.size() < n || got_b.size() < n) timeout(nm);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!(!a_busy && a_ready) && k < 2000) begin @(negedge clk); k++; end
    if (a_busy || !a_ready) timeout(nm);
    @(negedge clk);
  endtask

  task automatic wait_bits(input int n, input string nm);
    int k = 0;
    while (!(nb_a == n && !a_cs_n) && k < 1000) begin @(negedge clk); k++; end
    if (nb_a != n || a_cs_n) timeout(nm);
  endtask

  task automatic cmp_a(input string nm, input logic [15:0] want);
    if (got_a.size() == 0) timeout(nm);
    else check(nm, 32'(got_a.pop_front()), 32'(want));
  endtask

  task automatic cmp_b(input string nm, input logic [15:0] want);
    if (got_b.size() == 0) timeout(nm);
    else check(nm, 32'(got_b.pop_front()), 32'(want));
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] d;
      logic        e;
      d = 12'($urandom);
      e = (i % 16 == 15);
      send(d, e);
      exp_a.push_back(model_a(d));
      exp_b.push_back(model_b(d[7:0]));
      if (e) exp_periods++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("stream_idle");
    while (exp_a.size() > 0) cmp_a("rand_frame_a", exp_a.pop_front());
    while (exp_b.size() > 0) cmp_b("rand_frame_b", exp_b.pop_front());
  endtask

  typedef struct {
    logic [11:0] d;
    logic [15:0] fa;
    logic [15:0] fb;
  } vec_t;

  vec_t vt[4];

  initial begin
    int pulses0, aborts0;
    logic [15:0] cnt0;

    vt[0] = '{12'h800, 16'h3000, 16'h3000};
    vt[1] = '{12'h000, 16'h3800, 16'h3000};
    vt[2] = '{12'h7FF, 16'h3FFF, 16'h3FF0};
    vt[3] = '{12'h0A5, 16'h38A5, 16'h3A50};

    // ---- reset
    rst = 1'b1; en = 1'b1; valid = 1'b0; dend = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk",   32'(a_sclk),   32'd0);
    check("rst_mosi",   32'(a_mosi),   32'd0);
    check("rst_cs_n",   32'(a_cs_n),   32'd1);
    check("rst_ldac_n", 32'(a_ldac_n), 32'd1);
    check("rst_busy",   32'(a_busy),   32'd0);
    check("rst_ovr",    32'(a_ovr),    32'd0);
    check("rst_cnt",    32'(a_cnt),    32'd0);
    check("rst_ready",  32'(a_ready),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven frames: code conversion, frame length, LDAC width
    for (int i = 0; i < 4; i++) begin
      send(vt[i].d, 1'b0);
      wait_frames(1, "tbl_frame_wait");
      wait_idle("tbl_idle");
      cmp_a("tbl_frame_a", vt[i].fa);
      cmp_b("tbl_frame_b", vt[i].fb);
      check("tbl_frame_len", 32'(last_len),    32'd137);
      check("tbl_ldac_w",    32'(last_ldac_w), 32'd4);
    end

    // ---- back-to-back with one-deep buffering, then overrun
    check("b2b_ovr_pre", 32'(a_ovr), 32'd0);
    send(12'h123, 1'b0);
    begin
      int k = 0;
      while (a_cs_n && k < 100) begin @(negedge clk); k++; end
      if (a_cs_n) timeout("b2b_load_wait");
    end
    check("b2b_ready_in_load", 32'(a_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_after_load", 32'(a_ready), 32'd1);
    data = 12'h456; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("b2b_ready_full", 32'(a_ready), 32'd0);
    check("b2b_ovr_ok",     32'(a_ovr),   32'd0);
    data = 12'hABC; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("b2b_ovr_set", 32'(a_ovr), 32'd1);
    wait_frames(2, "b2b_frames");
    wait_idle("b2b_idle");
    check("b2b_gap", 32'(last_gap), 32'd1);
    cmp_a("b2b_frame1", 16'h3923);
    cmp_a("b2b_frame2", 16'h3C56);
    repeat (300) @(negedge clk);
    check("b2b_dropped", 32'(got_a.size()), 32'd0);
    got_b.delete();

    // ---- randomized stream with period counting and wrap
    stream(64);
    check("per_cnt_64",  32'(a_cnt), 32'(exp_periods));
    check("per_cnt_b",   32'(b_cnt), 32'(exp_periods));
    check("per_cnt_c64", 32'(c_cnt), 32'(exp_periods % 4));
    stream(16);
    check("per_cnt_80",  32'(a_cnt), 32'(exp_periods));
    check("per_cnt_c80", 32'(c_cnt), 32'(exp_periods % 4));

    // ---- abort mid-frame: end flag set, a second sample buffered
    pulses0 = ldac_pulses; aborts0 = aborts; cnt0 = a_cnt;
    send(12'h321, 1'b1);
    wait_bits(3, "abort_bit3");
    send(12'h555, 1'b1);
    wait_bits(7, "abort_bit7");
    en = 1'b0;
    @(negedge clk);
    check("abort_cs_n",  32'(a_cs_n),   32'd1);
    check("abort_sclk",  32'(a_sclk),   32'd0);
    check("abort_busy",  32'(a_busy),   32'd0);
    check("abort_ldac",  32'(a_ldac_n), 32'd1);
    check("abort_ready", 32'(a_ready),  32'd0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("abort_pulses", 32'(ldac_pulses), 32'(pulses0));
    check("abort_seen",   32'(aborts),      32'(aborts0 + 1));
    check("abort_cnt",    32'(a_cnt),       32'(cnt0));
    check("abort_ready2", 32'(a_ready),     32'd1);
    check("abort_busy2",  32'(a_busy),      32'd0);
    got_b.delete();
    send(12'h000, 1'b0);
    wait_frames(1, "abort_recover");
    wait_idle("abort_idle");
    cmp_a("abort_clean_frame", 16'h3800);
    check("abort_clean_len", 32'(last_len), 32'd137);
    check("abort_cnt_after", 32'(a_cnt),    32'(cnt0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
